instr_fetch_unit: RTL

//  Fetch stage directly downstream of the program counter. Takes Program_Count, fetches one 32-bit

---
 rtl/instr_fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues one read per PC over a req/gnt/rvalid bus
// and holds the returned word (or a fault NOP) in a single slot for decode.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | one cycle after reset release, no bus activity
// REQ   | request Program_Count (unless misaligned or a kill is pending)
// WAIT  | request granted, waiting for Imem_Rvalid or timeout
// HOLD  | output slot full, waiting for decode to consume it
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        Clk_Core,
    input  logic        Rst_Core_N,
    input  logic [31:0] Program_Count,
    input  logic        Flush,
    output logic        Pc_Advance,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Gnt,
    input  logic        Imem_Rvalid,
    input  logic [31:0] Imem_Rdata,
    output logic [31:0] Instr,
    output logic [31:0] Instr_PC,
    output logic        Instr_Valid,
    output logic [1:0]  Instr_Fault,
    input  logic        Decode_Ready
);

    localparam int unsigned      TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t        state;
    logic          kill_pending;
    logic [31:0]   req_pc;
    logic [TW-1:0] timer;

    logic pc_misaligned;
    logic granted;

    assign pc_misaligned = |Program_Count[1:0];
    // A pending kill blocks new requests so the stale response cannot be
    // mistaken for the answer to a fresh request.
    assign Imem_Req      = (state == ST_REQ) && !kill_pending && !pc_misaligned;
    assign granted       = Imem_Req && Imem_Gnt;
    assign Imem_Addr     = Program_Count;
    assign Pc_Advance    = ((state == ST_HOLD) && Decode_Ready) || Flush;

    // Fetch sequencing, output slot and stale-response tracking.
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state        <= ST_IDLE;
            Instr        <= NOP_INSTR;
            Instr_PC     <= 32'h0;
            Instr_Valid  <= 1'b0;
            Instr_Fault  <= FAULT_NONE;
            kill_pending <= 1'b0;
            req_pc       <= 32'h0;
            timer        <= '0;
        end else begin
            // Any response retires an older kill; a kill raised this same
            // cycle (assigned below) takes precedence.
            if (Imem_Rvalid) begin
                kill_pending <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    state <= ST_REQ;
                end

                ST_REQ: begin
                    if (Flush) begin
                        if (granted) begin
                            kill_pending <= 1'b1;
                        end
                    end else if (!kill_pending) begin
                        if (pc_misaligned) begin
                            Instr       <= NOP_INSTR;
                            Instr_PC    <= Program_Count;
                            Instr_Fault <= FAULT_MISALIGN;
                            Instr_Valid <= 1'b1;
                            state       <= ST_HOLD;
                        end else if (granted) begin
                            req_pc <= Program_Count;
                            timer  <= '0;
                            state  <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (Flush) begin
                        if (!Imem_Rvalid) begin
                            kill_pending <= 1'b1;
                        end
                        state <= ST_REQ;
                    end else if (Imem_Rvalid) begin
                        Instr       <= Imem_Rdata;
                        Instr_PC    <= req_pc;
                        Instr_Fault <= FAULT_NONE;
                        Instr_Valid <= 1'b1;
                        state       <= ST_HOLD;
                    end else if (timer == TIMER_LAST) begin
                        Instr        <= NOP_INSTR;
                        Instr_PC     <= req_pc;
                        Instr_Fault  <= FAULT_TIMEOUT;
                        Instr_Valid  <= 1'b1;
                        kill_pending <= 1'b1;
                        state        <= ST_HOLD;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                ST_HOLD: begin
                    if (Flush || Decode_Ready) begin
                        Instr_Valid <= 1'b0;
                        state       <= ST_REQ;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
